array_ctrl_seq: RTL



---
 rtl/array_ctrl_seq.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/array_ctrl_seq.sv
// -----------------------------------------------------------------------------
// array_ctrl_seq
//
// Command sequencer for the CIM macro. Accepts one command at a time
// (MAC / WRITE / READ / NOP) over a valid/ready handshake, drives the
// bank-side controls (stage A) for the RUN phase, and replays the same
// command timeline one cycle later on the adder-tree side (stage B).
// MAC operands are streamed bit-plane by bit-plane over MAC_BITS cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready == idle)
//   cmd_op          00 MAC, 01 WRITE, 10 READ, 11 NOP
//   cmd_bank        WRITE bank address
//   cmd_col         READ column address
//   cmd_wdata       bank operand
//   cmd_act         MAC planes, plane k = cmd_act[k*DATA_W +: DATA_W]
//   mac_en, w_en, bank_mux, data_op                stage A (bank array)
//   mac_en_and, data_and, col_mux,
//   acc_first, acc_last                             stage B (adder tree)
//   busy            command in flight
//   done            one-cycle pulse in the final (DRAIN) cycle
//   addr_err        one-cycle pulse in the first RUN cycle on a bad address
// -----------------------------------------------------------------------------
module array_ctrl_seq #(
  parameter int NUM_BANK = 16,
  parameter int NUM_COL  = 8,
  parameter int DATA_W   = 16,
  parameter int MAC_BITS = 4,
  localparam int BANK_AW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int COL_AW  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [BANK_AW-1:0]         cmd_bank,
  input  logic [COL_AW-1:0]          cmd_col,
  input  logic [DATA_W-1:0]          cmd_wdata,
  input  logic [DATA_W*MAC_BITS-1:0] cmd_act,
  output logic                       mac_en,
  output logic                       w_en,
  output logic [NUM_BANK-1:0]        bank_mux,
  output logic [DATA_W-1:0]          data_op,
  output logic                       mac_en_and,
  output logic [DATA_W-1:0]          data_and,
  output logic [NUM_COL-1:0]         col_mux,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic                       busy,
  output logic                       done,
  output logic                       addr_err
);

  localparam int CNT_W = (MAC_BITS > 1) ? $clog2(MAC_BITS) : 1;
  localparam int ACT_W = DATA_W * MAC_BITS;
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(MAC_BITS - 1);

  typedef enum logic [1:0] {
    OP_MAC   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // State and latched command
  // ---------------------------------------------------------------------------
  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  op_e                op_reg, op_next;
  logic [COL_AW-1:0]  col_reg, col_next;
  logic [ACT_W-1:0]   act_reg, act_next;

  // Stage A (bank side) output registers
  logic               mac_en_reg, mac_en_next;
  logic               w_en_reg, w_en_next;
  logic [NUM_BANK-1:0] bank_mux_reg, bank_mux_next;
  logic [DATA_W-1:0]  data_op_reg, data_op_next;

  // Stage B (adder-tree side) output registers
  logic               mac_en_and_reg, mac_en_and_next;
  logic [DATA_W-1:0]  data_and_reg, data_and_next;
  logic [NUM_COL-1:0] col_mux_reg, col_mux_next;
  logic               acc_first_reg, acc_first_next;
  logic               acc_last_reg, acc_last_next;

  logic               done_reg, done_next;
  logic               addr_err_reg, addr_err_next;

  logic               accept;
  op_e                cmd_op_e;
  logic [CNT_W-1:0]   cnt_last;
  logic               bank_oor;
  logic               col_oor;
  logic [NUM_BANK-1:0] bank_dec;
  logic [NUM_COL-1:0] col_dec;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = cmd_valid && (state_reg == ST_IDLE);

  // One-hot decoders only have outputs for legal addresses, so an
  // out-of-range address decodes to all zeros without extra masking.
  for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank_dec
    assign bank_dec[gi] = (cmd_bank == BANK_AW'(gi));
  end

  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col_dec
    assign col_dec[gi] = (col_reg == COL_AW'(gi));
  end

  assign bank_oor = ({1'b0, cmd_bank} >= (BANK_AW + 1)'(NUM_BANK));
  assign col_oor  = ({1'b0, cmd_col}  >= (COL_AW + 1)'(NUM_COL));

  // Last RUN beat index: MAC walks all bit-planes, everything else is 1 beat.
  assign cnt_last = (op_reg == OP_MAC) ? MAC_LAST : '0;

  // ---------------------------------------------------------------------------
  // FSM next state and command latch
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    col_next   = col_reg;
    act_next   = act_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          op_next    = cmd_op_e;
          col_next   = cmd_col;
          act_next   = cmd_act;
        end
      end
      ST_RUN: begin
        // Shift so the plane stage B needs next is always in the low slice.
        act_next = act_reg >> DATA_W;
        if (cnt_reg == cnt_last) begin
          state_next = ST_DRAIN;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage A: loaded on the accepting edge so it is visible for exactly the
  // RUN cycles; held while RUN continues, idle values otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    mac_en_next   = 1'b1;
    w_en_next     = 1'b0;
    bank_mux_next = '0;
    data_op_next  = '0;

    if (accept) begin
      case (cmd_op_e)
        OP_MAC: begin
          bank_mux_next = '1;
          data_op_next  = cmd_wdata;
        end
        OP_WRITE: begin
          w_en_next     = 1'b1;
          bank_mux_next = bank_dec;
          data_op_next  = DATA_W'(cmd_wdata[DATA_W/2-1:0]);
        end
        OP_READ: begin
          mac_en_next   = 1'b0;
          bank_mux_next = '1;
          data_op_next  = DATA_W'(cmd_wdata[DATA_W/4-1:0]);
        end
        default: begin
        end
      endcase
    end else if (state_next == ST_RUN) begin
      mac_en_next   = mac_en_reg;
      w_en_next     = w_en_reg;
      bank_mux_next = bank_mux_reg;
      data_op_next  = data_op_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: derived from the current RUN beat, so it lands one cycle after
  // the matching stage-A cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mac_en_and_next = 1'b1;
    data_and_next   = '0;
    col_mux_next    = '0;
    acc_first_next  = 1'b0;
    acc_last_next   = 1'b0;

    if (state_reg == ST_RUN) begin
      case (op_reg)
        OP_MAC: begin
          col_mux_next   = '1;
          data_and_next  = act_reg[DATA_W-1:0];
          acc_first_next = (cnt_reg == '0);
          acc_last_next  = (cnt_reg == MAC_LAST);
        end
        OP_READ: begin
          mac_en_and_next = 1'b0;
          data_and_next   = '1;
          col_mux_next    = col_dec;
        end
        default: begin
        end
      endcase
    end
  end

  // done coincides with DRAIN; addr_err with the first RUN cycle.
  always_comb begin
    done_next     = (state_next == ST_DRAIN);
    addr_err_next = accept &&
                    (((cmd_op_e == OP_WRITE) && bank_oor) ||
                     ((cmd_op_e == OP_READ)  && col_oor));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      op_reg         <= OP_NOP;
      col_reg        <= '0;
      act_reg        <= '0;
      mac_en_reg     <= 1'b1;
      w_en_reg       <= 1'b0;
      bank_mux_reg   <= '0;
      data_op_reg    <= '0;
      mac_en_and_reg <= 1'b1;
      data_and_reg   <= '0;
      col_mux_reg    <= '0;
      acc_first_reg  <= 1'b0;
      acc_last_reg   <= 1'b0;
      done_reg       <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      op_reg         <= op_next;
      col_reg        <= col_next;
      act_reg        <= act_next;
      mac_en_reg     <= mac_en_next;
      w_en_reg       <= w_en_next;
      bank_mux_reg   <= bank_mux_next;
      data_op_reg    <= data_op_next;
      mac_en_and_reg <= mac_en_and_next;
      data_and_reg   <= data_and_next;
      col_mux_reg    <= col_mux_next;
      acc_first_reg  <= acc_first_next;
      acc_last_reg   <= acc_last_next;
      done_reg       <= done_next;
      addr_err_reg   <= addr_err_next;
    end
  end

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign busy       = !cmd_ready;
  assign mac_en     = mac_en_reg;
  assign w_en       = w_en_reg;
  assign bank_mux   = bank_mux_reg;
  assign data_op    = data_op_reg;
  assign mac_en_and = mac_en_and_reg;
  assign data_and   = data_and_reg;
  assign col_mux    = col_mux_reg;
  assign acc_first  = acc_first_reg;
  assign acc_last   = acc_last_reg;
  assign done       = done_reg;
  assign addr_err   = addr_err_reg;

endmodule
